// File: rtl/instr_fetch.sv
// Instruction fetch stage.
//
// Drives a word-indexed instruction memory with a 1-cycle read latency and
// tracks the single outstanding response. The fetched {pc, instr} pair goes
// to decode over a valid/ready handshake. Branch/jump redirects come from
// execute. Misaligned redirect targets and out-of-range PCs raise a sticky
// fault.
//
// Parameters:
//   RESET_PC    byte PC loaded on reset (4-byte aligned)
//   IMEM_DEPTH  number of 32-bit words; word index >= IMEM_DEPTH faults
//
// Ports:
//   clk, rst        clock (rising edge), asynchronous active-high reset
//   fetch_en        permits new fetch issue
//   redirect_valid  one-cycle redirect request, target in redirect_pc
//   imem_addr       word index (pc >> 2) to memory
//   imem_rd_en      memory read enable
//   imem_instr      memory read data, valid the cycle after imem_rd_en
//   if_valid        instruction available to decode
//   if_ready        decode accepts the instruction
//   if_pc           byte PC of the presented instruction
//   if_instr        presented instruction (memory data pass-through)
//   fetch_fault     sticky fault flag
//   fault_pc        PC that caused the fault
//
// Optional build macro INSTR_FETCH_PERF_EN adds perf_fetch_cnt (accepted
// instructions) and perf_stall_cnt (cycles with if_valid & !if_ready).

module instr_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_DEPTH = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_en,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_addr,
  output logic        imem_rd_en,
  input  logic [31:0] imem_instr,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic        fetch_fault,
`ifdef INSTR_FETCH_PERF_EN
  output logic [31:0] fault_pc,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_stall_cnt
`else
  output logic [31:0] fault_pc
`endif
);

  typedef enum logic [1:0] {StIdle, StRun, StFault} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic        resp_vld_q, resp_vld_d;
  logic        fault_q, fault_d;
  logic [31:0] fault_pc_q, fault_pc_d;

  logic [31:0] word_idx;
  logic        in_range;
  logic        slot_ok;
  logic        issue;
  logic        out_of_range;
  logic        fire;

  assign word_idx = {2'b00, pc_q[31:2]};
  assign in_range = word_idx < 32'(IMEM_DEPTH);

  // A new request may go out only if the response slot is empty or is being
  // drained this cycle; the memory output then changes exactly when decode
  // has taken the old word.
  assign slot_ok      = (state_q == StRun) & fetch_en & ~redirect_valid &
                        (~resp_vld_q | if_ready);
  assign issue        = slot_ok & in_range;
  assign out_of_range = slot_ok & ~in_range;

  assign if_valid    = resp_vld_q & ~redirect_valid & (state_q != StIdle);
  assign fire        = if_valid & if_ready;
  assign if_pc       = req_pc_q;
  assign if_instr    = imem_instr;
  assign imem_addr   = word_idx;
  assign imem_rd_en  = issue;
  assign fetch_fault = fault_q;
  assign fault_pc    = fault_pc_q;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_pc_d   = req_pc_q;
    resp_vld_d = resp_vld_q;
    fault_d    = fault_q;
    fault_pc_d = fault_pc_q;

    if (state_q == StIdle) begin
      // Redirects are ignored until fetching has been enabled once.
      if (fetch_en) begin
        state_d = StRun;
      end
    end else if (redirect_valid) begin
      // Anything in flight or presented belongs to the wrong path.
      resp_vld_d = 1'b0;
      pc_d       = redirect_pc;
      if (redirect_pc[1:0] == 2'b00) begin
        state_d = StRun;
        fault_d = 1'b0;
      end else begin
        state_d    = StFault;
        fault_d    = 1'b1;
        fault_pc_d = redirect_pc;
      end
    end else begin
      if (issue) begin
        req_pc_d   = pc_q;
        pc_d       = pc_q + 32'd4;
        resp_vld_d = 1'b1;
      end else if (fire) begin
        resp_vld_d = 1'b0;
      end
      // A pending response is still delivered after an out-of-range fault.
      if (out_of_range) begin
        state_d    = StFault;
        fault_d    = 1'b1;
        fault_pc_d = pc_q;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      pc_q       <= RESET_PC;
      req_pc_q   <= RESET_PC;
      resp_vld_q <= 1'b0;
      fault_q    <= 1'b0;
      fault_pc_q <= 32'h0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_pc_q   <= req_pc_d;
      resp_vld_q <= resp_vld_d;
      fault_q    <= fault_d;
      fault_pc_q <= fault_pc_d;
    end
  end

`ifdef INSTR_FETCH_PERF_EN
  logic [31:0] perf_fetch_q;
  logic [31:0] perf_stall_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetch_q <= 32'h0;
      perf_stall_q <= 32'h0;
    end else begin
      if (fire) begin
        perf_fetch_q <= perf_fetch_q + 32'd1;
      end
      if (if_valid & ~if_ready) begin
        perf_stall_q <= perf_stall_q + 32'd1;
      end
    end
  end

  assign perf_fetch_cnt = perf_fetch_q;
  assign perf_stall_cnt = perf_stall_q;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch.
// Instance u_dut (IMEM_DEPTH=1024) covers streaming, backpressure, redirects,
// misaligned-target faults and reset. Accepted instructions are checked
// against a scoreboard of expected {pc, instr} pairs. Instance u_dut_small
// (IMEM_DEPTH=4) covers the out-of-range fault.

module tb_instr_fetch;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Main instance signals
  logic        fetch_en, redirect_valid, if_ready;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr, imem_instr, if_pc, if_instr, fault_pc;
  logic        imem_rd_en, if_valid, fetch_fault;

  // Small-memory instance signals
  logic        b_fetch_en, b_if_ready;
  logic [31:0] b_addr, b_instr, b_if_pc, b_if_instr, b_fault_pc;
  logic        b_rd_en, b_if_valid, b_fault;

`ifdef INSTR_FETCH_PERF_EN
  logic [31:0] perf_fetch_cnt, perf_stall_cnt, b_perf_fetch, b_perf_stall;
`endif

  instr_fetch #(.RESET_PC(32'h0), .IMEM_DEPTH(1024)) u_dut (
    .clk            (clk),
    .rst            (rst),
    .fetch_en       (fetch_en),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_addr      (imem_addr),
    .imem_rd_en     (imem_rd_en),
    .imem_instr     (imem_instr),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_pc          (if_pc),
    .if_instr       (if_instr),
    .fetch_fault    (fetch_fault),
`ifdef INSTR_FETCH_PERF_EN
    .fault_pc       (fault_pc),
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_stall_cnt (perf_stall_cnt)
`else
    .fault_pc       (fault_pc)
`endif
  );

  instr_fetch #(.RESET_PC(32'h0), .IMEM_DEPTH(4)) u_dut_small (
    .clk            (clk),
    .rst            (rst),
    .fetch_en       (b_fetch_en),
    .redirect_valid (1'b0),
    .redirect_pc    (32'h0),
    .imem_addr      (b_addr),
    .imem_rd_en     (b_rd_en),
    .imem_instr     (b_instr),
    .if_valid       (b_if_valid),
    .if_ready       (b_if_ready),
    .if_pc          (b_if_pc),
    .if_instr       (b_if_instr),
    .fetch_fault    (b_fault),
`ifdef INSTR_FETCH_PERF_EN
    .fault_pc       (b_fault_pc),
    .perf_fetch_cnt (b_perf_fetch),
    .perf_stall_cnt (b_perf_stall)
`else
    .fault_pc       (b_fault_pc)
`endif
  );

  // Memory model: word i holds 0x13 + i, 1-cycle latency, holds when not read
  logic [31:0] mem [256];
  initial for (int i = 0; i < 256; i++) mem[i] = 32'h13 + i;

  always @(posedge clk) if (imem_rd_en) imem_instr <= mem[imem_addr[7:0]];
  always @(posedge clk) if (b_rd_en) b_instr <= mem[b_addr[7:0]];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } item_t;

  item_t sb_q[$];

  function automatic void push_exp(input logic [31:0] pc);
    sb_q.push_back({pc, mem[pc[9:2]]});
  endfunction

  // Every handshake on the main instance must match the next expected item
  always @(negedge clk) begin
    if (rst === 1'b0 && if_valid === 1'b1 && if_ready === 1'b1) begin
      check_eq("sb_avail", {31'b0, sb_q.size() != 0}, 32'd1);
      if (sb_q.size() != 0) begin
        item_t e;
        e = sb_q.pop_front();
        check_eq("sb_pc", if_pc, e.pc);
        check_eq("sb_instr", if_instr, e.instr);
      end
    end
  end

  // Inputs change just after the rising edge; outputs are sampled mid-cycle
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample_point();
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_valid"}, {31'b0, if_valid}, 32'd0);
    check_eq({tag, "_rd_en"}, {31'b0, imem_rd_en}, 32'd0);
    check_eq({tag, "_addr"}, imem_addr, 32'h0);
    check_eq({tag, "_fault"}, {31'b0, fetch_fault}, 32'd0);
    check_eq({tag, "_fault_pc"}, fault_pc, 32'h0);
    check_eq({tag, "_if_pc"}, if_pc, 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    fetch_en = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0; if_ready = 1'b0;
    b_fetch_en = 1'b0; b_if_ready = 1'b0;
    repeat (2) @(posedge clk);
    sample_point();
    check_reset_outputs("rst");
    check_eq("rst_b_rd_en", {31'b0, b_rd_en}, 32'd0);
    check_eq("rst_b_fault", {31'b0, b_fault}, 32'd0);

    // Streaming from reset: IDLE->RUN, rd_en at cycle 1, if_valid at cycle 2
    next_cycle(); rst = 1'b0; fetch_en = 1'b1; if_ready = 1'b1;
    push_exp(32'h0); push_exp(32'h4); push_exp(32'h8); push_exp(32'hC);
    sample_point();
    check_eq("c0_rd_en", {31'b0, imem_rd_en}, 32'd0);
    check_eq("c0_valid", {31'b0, if_valid}, 32'd0);
    next_cycle(); sample_point();
    check_eq("c1_rd_en", {31'b0, imem_rd_en}, 32'd1);
    check_eq("c1_addr", imem_addr, 32'h0);
    check_eq("c1_valid", {31'b0, if_valid}, 32'd0);
    next_cycle(); sample_point();
    check_eq("c2_valid", {31'b0, if_valid}, 32'd1);
    check_eq("c2_pc", if_pc, 32'h0);
    check_eq("c2_instr", if_instr, 32'h13);
    next_cycle(); sample_point();
    check_eq("c3_pc", if_pc, 32'h4);

    // Backpressure for 3 cycles while pc 8 is presented
    next_cycle(); if_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      sample_point();
      check_eq("stall_valid", {31'b0, if_valid}, 32'd1);
      check_eq("stall_pc", if_pc, 32'h8);
      check_eq("stall_instr", if_instr, 32'h15);
      check_eq("stall_rd_en", {31'b0, imem_rd_en}, 32'd0);
      next_cycle();
    end
    if_ready = 1'b1;
    sample_point();
    check_eq("release_pc", if_pc, 32'h8);
    next_cycle(); sample_point();
    check_eq("after_release_pc", if_pc, 32'hC);

    // Redirect to 0x40 while pc 0x10 is presented
    next_cycle(); redirect_valid = 1'b1; redirect_pc = 32'h40; push_exp(32'h40);
    sample_point();
    check_eq("redir_kill_valid", {31'b0, if_valid}, 32'd0);
    check_eq("redir_rd_en", {31'b0, imem_rd_en}, 32'd0);
    next_cycle(); redirect_valid = 1'b0;
    sample_point();
    check_eq("redir_t1_rd_en", {31'b0, imem_rd_en}, 32'd1);
    check_eq("redir_t1_addr", imem_addr, 32'h10);
    next_cycle(); sample_point();
    check_eq("redir_t2_valid", {31'b0, if_valid}, 32'd1);
    check_eq("redir_t2_pc", if_pc, 32'h40);
    check_eq("redir_t2_instr", if_instr, 32'h23);

    // Misaligned redirect target faults
    next_cycle(); redirect_valid = 1'b1; redirect_pc = 32'h42;
    sample_point();
    check_eq("mis_kill_valid", {31'b0, if_valid}, 32'd0);
    next_cycle(); redirect_valid = 1'b0;
    sample_point();
    check_eq("mis_fault", {31'b0, fetch_fault}, 32'd1);
    check_eq("mis_fault_pc", fault_pc, 32'h42);
    check_eq("mis_rd_en", {31'b0, imem_rd_en}, 32'd0);
    check_eq("mis_valid", {31'b0, if_valid}, 32'd0);
    next_cycle(); sample_point();
    check_eq("mis_hold_rd_en", {31'b0, imem_rd_en}, 32'd0);
    check_eq("mis_hold_fault", {31'b0, fetch_fault}, 32'd1);

    // Recovery by redirect to 0x80
    next_cycle(); redirect_valid = 1'b1; redirect_pc = 32'h80;
    push_exp(32'h80); push_exp(32'h84);
    sample_point();
    next_cycle(); redirect_valid = 1'b0;
    sample_point();
    check_eq("rec_fault", {31'b0, fetch_fault}, 32'd0);
    check_eq("rec_rd_en", {31'b0, imem_rd_en}, 32'd1);
    check_eq("rec_addr", imem_addr, 32'h20);
    next_cycle(); sample_point();
    check_eq("rec_pc", if_pc, 32'h80);
    check_eq("rec_instr", if_instr, 32'h33);
    next_cycle(); fetch_en = 1'b0;
    sample_point();
    check_eq("fen_low_pending_valid", {31'b0, if_valid}, 32'd1);
    check_eq("fen_low_rd_en", {31'b0, imem_rd_en}, 32'd0);
    next_cycle(); sample_point();
    check_eq("fen_low_drained", {31'b0, if_valid}, 32'd0);

    // Reset, then a redirect while IDLE must be ignored
    next_cycle(); rst = 1'b1;
    sample_point();
    next_cycle(); rst = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h42;
    sample_point();
    next_cycle(); redirect_valid = 1'b0;
    sample_point();
    check_eq("idle_redir_fault", {31'b0, fetch_fault}, 32'd0);
    check_eq("idle_redir_addr", imem_addr, 32'h0);

    // Stream up to pc 0x20, then reset asynchronously mid-cycle
    next_cycle(); fetch_en = 1'b1; if_ready = 1'b1;
    for (int i = 0; i < 8; i++) push_exp(32'(i * 4));
    sample_point();
    for (int k = 0; k < 9; k++) begin
      next_cycle(); sample_point();
    end
    next_cycle(); if_ready = 1'b0;
    sample_point();
    check_eq("pre_rst_valid", {31'b0, if_valid}, 32'd1);
    check_eq("pre_rst_pc", if_pc, 32'h20);
    #1 rst = 1'b1;
    #1 check_reset_outputs("async_rst");
    check_eq("sb_empty_at_rst", 32'(sb_q.size()), 32'd0);

    // Restart from RESET_PC
    next_cycle(); next_cycle(); rst = 1'b0; fetch_en = 1'b1; if_ready = 1'b1;
    push_exp(32'h0); push_exp(32'h4);
    sample_point();
    next_cycle(); sample_point();
    check_eq("restart_addr", imem_addr, 32'h0);
    check_eq("restart_rd_en", {31'b0, imem_rd_en}, 32'd1);
    next_cycle(); sample_point();
    check_eq("restart_valid", {31'b0, if_valid}, 32'd1);
    check_eq("restart_pc", if_pc, 32'h0);
    next_cycle(); fetch_en = 1'b0;
    sample_point();
    next_cycle(); sample_point();
    check_eq("restart_drained", {31'b0, if_valid}, 32'd0);
    check_eq("sb_drain", 32'(sb_q.size()), 32'd0);

    // Small memory: four words delivered, then out-of-range fault at 0x10
    next_cycle(); rst = 1'b1;
    next_cycle(); rst = 1'b0; b_fetch_en = 1'b1; b_if_ready = 1'b1;
    sample_point();
    check_eq("sm_c0_rd_en", {31'b0, b_rd_en}, 32'd0);
    for (int k = 1; k <= 7; k++) begin
      next_cycle(); sample_point();
      check_eq("sm_rd_en", {31'b0, b_rd_en}, {31'b0, (k >= 1 && k <= 4)});
      check_eq("sm_valid", {31'b0, b_if_valid}, {31'b0, (k >= 2 && k <= 5)});
      if (k >= 2 && k <= 5) begin
        check_eq("sm_pc", b_if_pc, 32'((k - 2) * 4));
        check_eq("sm_instr", b_if_instr, 32'h13 + 32'(k - 2));
      end
      check_eq("sm_fault", {31'b0, b_fault}, {31'b0, (k >= 6)});
      if (k >= 6) check_eq("sm_fault_pc", b_fault_pc, 32'h10);
    end
`ifdef INSTR_FETCH_PERF_EN
    check_eq("sm_perf_fetch", b_perf_fetch, 32'd4);
    check_eq("sm_perf_stall", b_perf_stall, 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
